// File: rtl/weight_mem_pkg.sv
// weight_mem_pkg: shared constants for the weight SRAM and its read sequencer.
//   - word geometry (25 pixels x 4b = 100b words), address/length widths
//   - per-layer region bases inside the 20000-word SRAM
//   - fetch sequencer state encoding
package weight_mem_pkg;

    localparam int WEIGHT_WIDTH     = 4;
    localparam int WEIGHT_PIXEL_NUM = 25;
    localparam int WORD_W           = WEIGHT_WIDTH * WEIGHT_PIXEL_NUM;
    localparam int ADDR_W           = 17;
    localparam int LEN_W            = 15;
    localparam int MEM_DEPTH        = 20000;

    // Region bases (word index); sizes in the trailing comment.
    localparam int CONV1_W = 0;      // 20 words
    localparam int CONV1_B = 20;     // 1 word
    localparam int CONV2_W = 21;     // 1000 words
    localparam int CONV2_B = 1021;   // 2 words
    localparam int FC1_W   = 1100;   // 16000 words
    localparam int SCORE_W = 17100;  // 200 words

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/weight_fifo.sv
// weight_fifo: synchronous FIFO, WIDTH x DEPTH, with occupancy count.
//   clk, rst       : clock, synchronous active-high reset (flushes pointers/count)
//   push/push_data : write side; a push while full is taken only with a pop
//   pop/pop_data   : read side; pop_data is the head word, zero when empty
//   count, empty   : occupancy
module weight_fifo #(
    parameter int WIDTH = 101,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             full, wr_en, rd_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Gate the head with empty so the output reads zero after a flush.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: read sequencer for the weight SRAM.
//   cmd_*       : layer fetch command (base, len); cmd_err pulses on a bad range
//   sram_*      : SRAM read port, csb active-low, data returns one cycle later
//   w_*         : valid/ready weight word stream, w_last on the final word
//   done        : pulses in the cycle the final word is popped
// Reads are credit-limited so FIFO words plus reads in flight never exceed
// FIFO_DEPTH; no read can ever arrive to a full buffer.
module weight_fetch_ctrl
    import weight_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_DEPTH  = weight_mem_pkg::MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_err,
    output logic              sram_csb,
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [WORD_W-1:0] sram_rdata,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_data,
    output logic              w_last,
    output logic              done
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              issue, issue_d, last_d;
    logic              accept, cmd_ok, credit_ok, pop, fifo_empty;
    logic [CW-1:0]     fifo_count;

    // 18-bit range check so base+len cannot wrap.
    assign cmd_ok = (cmd_len != '0) &&
                    (({1'b0, cmd_base} + 18'(cmd_len)) <= 18'(MEM_DEPTH));

    assign cmd_ready = (state == ST_IDLE) && !cmd_err;
    assign accept    = cmd_valid && cmd_ready;

    // issue_d is the only read that can be in flight (issued, not yet written).
    assign credit_ok = ({1'b0, fifo_count} + (CW+1)'(issue_d)) < (CW+1)'(FIFO_DEPTH);
    assign issue     = (state == ST_FETCH) && credit_ok;

    assign sram_csb   = !issue;
    assign sram_raddr = addr;

    assign w_valid = !fifo_empty;
    assign pop     = w_valid && w_ready;
    assign done    = pop && w_last && (state == ST_DRAIN);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept && cmd_ok) state_nxt = ST_FETCH;
            ST_FETCH: if (issue && remaining == LEN_W'(1)) state_nxt = ST_DRAIN;
            ST_DRAIN: if (pop && w_last) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            issue_d   <= 1'b0;
            last_d    <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cmd_err <= accept && !cmd_ok;
            issue_d <= issue;
            last_d  <= issue && (remaining == LEN_W'(1));
            if (accept && cmd_ok) begin
                addr      <= cmd_base;
                remaining <= cmd_len;
            end else if (issue) begin
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

    weight_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue_d),
        .push_data ({last_d, sram_rdata}),
        .pop       (pop),
        .pop_data  ({w_last, w_data}),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// tb_weight_fetch_ctrl: directed + randomized bench for weight_fetch_ctrl.
// The reference model expands each accepted command into its expected word
// list (queue) and read-address sequence; the monitor scores every cycle.
module tb_weight_fetch_ctrl;

    localparam int MEMD  = 20000;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready, cmd_err;
    logic [16:0]  cmd_base;
    logic [14:0]  cmd_len;
    logic         sram_csb;
    logic [16:0]  sram_raddr;
    logic [99:0]  sram_rdata;
    logic         w_valid, w_ready, w_last, done;
    logic [99:0]  w_data;

    weight_fetch_ctrl #(.FIFO_DEPTH(DEPTH), .MEM_DEPTH(MEMD)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_err(cmd_err),
        .sram_csb(sram_csb), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_last(w_last), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // SRAM model: 1-cycle read latency.
    logic [99:0] mem [MEMD];
    always @(posedge clk) begin
        if (!sram_csb)
            sram_rdata <= (int'(sram_raddr) < MEMD) ? mem[sram_raddr] : '0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model / scoreboard state.
    logic [100:0] exp_q [$];
    int  rd_next, rd_left, reads_cmd, pops_cmd;
    int  acc_cyc, first_wv_cyc, first_pop_cyc, done_cyc, err_cyc;
    bit  err_exp, prev_stall;
    logic [100:0] prev_word;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            err_exp    = 1'b0;
            prev_stall = 1'b0;
            rd_left    = 0;
        end else begin
            check("cmd_err", cmd_err, err_exp);
            check("cmd_ready", cmd_ready, (exp_q.size() == 0) && !err_exp);
            if (cmd_err) err_cyc = cyc;
            err_exp = 1'b0;
            if (!sram_csb) begin
                check("read_expected", rd_left != 0, 1'b1);
                check("raddr", sram_raddr, rd_next);
                reads_cmd++;
                check("fifo_bound", (reads_cmd - pops_cmd) <= DEPTH, 1'b1);
                rd_next++;
                if (rd_left > 0) rd_left--;
            end
            if (prev_stall) begin
                check("stall_valid", w_valid, 1'b1);
                check("stall_word", {w_last, w_data}, prev_word);
            end
            if (w_valid) begin
                check("valid_has_word", exp_q.size() != 0, 1'b1);
                if (first_wv_cyc < 0) first_wv_cyc = cyc;
            end
            if (w_valid && w_ready && exp_q.size() != 0) begin
                logic [100:0] e;
                e = exp_q.pop_front();
                check("w_data", w_data, e[99:0]);
                check("w_last", w_last, e[100]);
                check("done_on_pop", done, e[100]);
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                pops_cmd++;
            end else begin
                check("done_idle", done, 1'b0);
            end
            if (done) done_cyc = cyc;
            prev_stall = w_valid && !w_ready;
            prev_word  = {w_last, w_data};
            if (cmd_valid && cmd_ready) begin
                acc_cyc = cyc; first_wv_cyc = -1; first_pop_cyc = -1;
                done_cyc = -1; err_cyc = -1; reads_cmd = 0; pops_cmd = 0;
                if (cmd_len != 0 && int'(cmd_base) + int'(cmd_len) <= MEMD) begin
                    for (int i = 0; i < int'(cmd_len); i++)
                        exp_q.push_back({(i == int'(cmd_len) - 1), mem[int'(cmd_base) + i]});
                    rd_next = int'(cmd_base);
                    rd_left = int'(cmd_len);
                end else begin
                    err_exp = 1'b1;
                    rd_left = 0;
                end
            end
        end
    end

    // w_ready driver: 0 = high, 1 = toggle, 2 = random, 3 = held low.
    int ready_mode = 0;
    initial begin
        w_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       w_ready = 1'b1;
                1:       w_ready = ~w_ready;
                2:       w_ready = 1'($urandom_range(0, 1));
                default: w_ready = 1'b0;
            endcase
        end
    end

    task automatic send_cmd(input int base, input int len);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 2000);
        check("cmd_ready_wait", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_base = 17'(base); cmd_len = 15'(len);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        bit timed_out = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && cmd_ready) && n < 5000);
        timed_out = (n >= 5000);
        check("idle_timeout", timed_out, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        check({tag, "_cmd_err"}, cmd_err, 1'b0);
        check({tag, "_csb"}, sram_csb, 1'b1);
        check({tag, "_raddr"}, sram_raddr, 17'd0);
        check({tag, "_w_valid"}, w_valid, 1'b0);
        check({tag, "_w_data"}, w_data, 100'd0);
        check({tag, "_w_last"}, w_last, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEMD; i++) begin
            logic [127:0] r;
            r = {$urandom, $urandom, $urandom, $urandom};
            mem[i] = r[99:0];
        end
        rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        // Full-rate stream of a small region.
        send_cmd(0, 20);
        wait_idle();
        check("t1_first_valid", first_wv_cyc - acc_cyc, 3);
        check("t1_done_cycle", done_cyc - acc_cyc, 22);
        check("t1_reads", reads_cmd, 20);
        check("t1_pops", pops_cmd, 20);

        // Toggling backpressure.
        ready_mode = 1;
        send_cmd(17100, 200);
        wait_idle();
        check("t2_reads", reads_cmd, 200);
        check("t2_pops", pops_cmd, 200);

        // Hold-off: only FIFO_DEPTH reads until the consumer frees credits.
        ready_mode = 3;
        @(posedge clk);
        send_cmd(500, 30);
        repeat (10) @(negedge clk);
        check("t3_stall_reads", reads_cmd, 4);
        ready_mode = 0;
        wait_idle();
        check("t3_no_gaps", done_cyc - first_pop_cyc, 29);
        check("t3_pops", pops_cmd, 30);

        // Rejected commands, then a command ending exactly at the top.
        send_cmd(19990, 11);
        wait_idle();
        check("t4_err_cycle", err_cyc - acc_cyc, 1);
        check("t4_reads", reads_cmd, 0);
        send_cmd(100, 0);
        wait_idle();
        check("t4z_err_cycle", err_cyc - acc_cyc, 1);
        check("t4z_reads", reads_cmd, 0);
        send_cmd(19990, 10);
        wait_idle();
        check("t4ok_pops", pops_cmd, 10);

        // Reset mid-stream, then restart from a new base.
        send_cmd(21, 1000);
        begin
            int n = 0;
            while (pops_cmd < 5 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("t5_reached_word5", pops_cmd >= 5, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("t5");
        send_cmd(1100, 50);
        wait_idle();
        check("t5_pops", pops_cmd, 50);

        // Single-word command.
        send_cmd(1021, 1);
        wait_idle();
        check("t6_done_cycle", done_cyc - acc_cyc, 3);
        check("t6_pops", pops_cmd, 1);

        // Randomized commands under random backpressure.
        ready_mode = 2;
        for (int k = 0; k < 25; k++) begin
            int b, l, sel;
            sel = $urandom_range(0, 5);
            l   = (sel == 0) ? 0 : $urandom_range(1, 40);
            if (sel == 1) b = MEMD - l + $urandom_range(0, 1);
            else          b = $urandom_range(0, MEMD - 1);
            send_cmd(b, l);
            wait_idle();
            if (l != 0 && b + l <= MEMD) check("rand_pops", pops_cmd, l);
            else                         check("rand_err_reads", reads_cmd, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
